// File: rtl/prio_enc_q_if.sv
// Issue channel of prio_enc_q: one encoded request index per valid/ready transfer.
// A transfer happens on a rising clk edge where out_valid & out_ready; while out_valid is high and
// out_ready is low the producer keeps out_valid and out_idx stable, and out_ready may change at any time.
interface prio_enc_q_if #(
    parameter int IW = 3
);
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;

    modport master (
        output out_valid,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        output out_ready
    );
endinterface

// File: rtl/prio_enc_q.sv
// Registered priority encoder with a pending register: request pulses are latched, then issued one index
// at a time, either highest-index-first or round-robin.
module prio_enc_q #(
    parameter int N    = 8,
    parameter int IW   = $clog2(N),
    parameter int MODE = 0,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    prio_enc_q_if.master  issue,
    output logic [N-1:0]  pending,
    output logic          busy,
    output logic [CW-1:0] merge_cnt
);

    localparam int SW = CW + $clog2(N + 1) + 1;
    localparam logic [SW-1:0] CMAX = SW'({CW{1'b1}});

    logic [IW-1:0] last;
    logic          load_en;
    logic          do_load;
    logic [IW-1:0] sel;
    logic [N-1:0]  below;
    logic [N-1:0]  low_pend;
    logic [N-1:0]  load_mask;
    logic [N-1:0]  merged;
    logic [SW-1:0] merge_add;
    logic [SW-1:0] merge_sum;
    logic [CW-1:0] merge_next;

    function automatic logic [IW-1:0] top_idx(input logic [N-1:0] v);
        top_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) top_idx = IW'(i);
        end
    endfunction

    // Round-robin: bits below last are searched first (last-1 down to 0); if none, wrap to the full vector.
    always_comb begin
        below = '0;
        for (int i = 0; i < N; i++) begin
            below[i] = (i < int'(last));
        end
        low_pend = pending & below;
        if (MODE == 1 && low_pend != '0) sel = top_idx(low_pend);
        else                             sel = top_idx(pending);
    end

    assign load_en   = !issue.out_valid | issue.out_ready;
    assign do_load   = load_en & (|pending);
    assign load_mask = do_load ? (N'(1) << sel) : '0;
    assign merged    = req & pending & ~load_mask;
    assign busy      = issue.out_valid | (|pending);

    always_comb begin
        merge_add = '0;
        for (int i = 0; i < N; i++) begin
            merge_add = merge_add + SW'(merged[i]);
        end
        merge_sum  = SW'(merge_cnt) + merge_add;
        merge_next = (merge_sum > CMAX) ? {CW{1'b1}} : merge_sum[CW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending         <= '0;
            issue.out_valid <= 1'b0;
            issue.out_idx   <= '0;
            merge_cnt       <= '0;
            last            <= '0;
        end else begin
            pending   <= (pending & ~load_mask) | req;
            merge_cnt <= merge_next;
            if (load_en) begin
                if (do_load) begin
                    issue.out_idx   <= sel;
                    issue.out_valid <= 1'b1;
                    last            <= sel;
                end else begin
                    issue.out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
